lsu_bus_master: RTL and testbench

//  Load/store unit between the core execute stage and the word-addressed memory port.

---
 rtl/lsu_bus_master.sv | 261 ++++++++++++++++++++++++++
 tb/tb_lsu_bus_master.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_master.sv
// +----------------------------------------------------------------------------+
// | Module      : lsu_bus_master                                               |
// | Description : Load/store unit between the core execute stage and a         |
// |               word-addressed memory port. Accepts one byte/half/word load  |
// |               or store, builds the byte-lane mask and lane-replicated      |
// |               write data, strobes the memory for one cycle, waits for      |
// |               mem_done_i and returns sign/zero-extended load data. A       |
// |               watchdog turns an unanswered access into an error response.  |
// | Config      : `define LSU_MISALIGN_TRAP_EN to trap misaligned half/word    |
// |               accesses (error response, no strobe). When undefined the     |
// |               low address bits are ignored for halves and words.           |
// | Parameters  : TIMEOUT_CYCLES - WAIT cycles without mem_done_i before an    |
// |               error response (1..255).                                     |
// | Ports       : clk, rst        - clock, synchronous active-high reset       |
// |               req_*_i/_o      - core request (valid/ready handshake)       |
// |               resp_*_o        - one-cycle response pulse with data/error   |
// |               mem_*_o         - address, data, lane mask, write/read strobe|
// |               mem_rdata_i     - registered read word from memory           |
// |               mem_done_i      - memory transaction complete                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module lsu_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  // core request
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  // core response
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  // memory port
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wmask_o,
  output logic        mem_wstrobe_o,
  output logic        mem_rstrobe_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_done_i
);

  localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      state_q,  state_d;
  logic        we_q,     we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q,   addr_d;
  logic [31:0] wdata_q,  wdata_d;
  logic [3:0]  wmask_q,  wmask_d;
  logic        err_q,    err_d;
  logic [31:0] rdata_q,  rdata_d;
  logic [7:0]  cnt_q,    cnt_d;

  // --------------------------------------------------------------------------
  // Request decode (evaluated on the incoming request while IDLE)
  // --------------------------------------------------------------------------
  logic        w_illegal;
  logic        w_bad_store;
  logic        w_misalign;
  logic        w_bad_req;
  logic [1:0]  w_lane;
  logic [31:0] w_req_wdata;
  logic [3:0]  w_req_wmask;

  assign w_lane      = req_addr_i[1:0];
  assign w_illegal   = (req_funct3_i == 3'b011) || (req_funct3_i == 3'b110) ||
                       (req_funct3_i == 3'b111);
  // Stores have no unsigned variants, so funct3[2] set is illegal for them.
  assign w_bad_store = req_we_i && req_funct3_i[2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign  = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                       ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
  // Halves use only addr[1], words ignore addr[1:0]: nothing is misaligned.
  assign w_misalign  = 1'b0;
`endif

  assign w_bad_req   = w_illegal || w_bad_store || w_misalign;

  // Store lane placement: data is replicated across the word so that the
  // memory only needs the mask to pick the right lanes.
  always_comb begin
    w_req_wdata = 32'd0;
    w_req_wmask = 4'b0000;
    if (req_we_i) begin
      case (req_funct3_i[1:0])
        2'b00: begin
          w_req_wdata = {4{req_wdata_i[7:0]}};
          w_req_wmask = 4'b0001 << w_lane;
        end
        2'b01: begin
          w_req_wdata = {2{req_wdata_i[15:0]}};
          w_req_wmask = 4'b0011 << {w_lane[1], 1'b0};
        end
        2'b10: begin
          w_req_wdata = req_wdata_i;
          w_req_wmask = 4'b1111;
        end
        default: begin
          w_req_wdata = 32'd0;
          w_req_wmask = 4'b0000;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Load data extraction from the returned word (latched address/width)
  // --------------------------------------------------------------------------
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_data;

  always_comb begin
    case (addr_q[1:0])
      2'b00:   w_ld_byte = mem_rdata_i[7:0];
      2'b01:   w_ld_byte = mem_rdata_i[15:8];
      2'b10:   w_ld_byte = mem_rdata_i[23:16];
      default: w_ld_byte = mem_rdata_i[31:24];
    endcase
  end

  assign w_ld_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

  always_comb begin
    case (funct3_q)
      3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'b010:  w_ld_data = mem_rdata_i;
      3'b100:  w_ld_data = {24'd0, w_ld_byte};
      3'b101:  w_ld_data = {16'd0, w_ld_half};
      default: w_ld_data = 32'd0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (req_valid_i) begin
          we_d     = req_we_i;
          funct3_d = req_funct3_i;
          addr_d   = req_addr_i;
          rdata_d  = 32'd0;
          if (w_bad_req) begin
            // Rejected without touching memory.
            err_d   = 1'b1;
            wmask_d = 4'b0000;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            wdata_d = w_req_wdata;
            wmask_d = w_req_wmask;
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        // mem_done_i may still be high from the previous access; not sampled here.
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (mem_done_i) begin
          rdata_d = we_q ? 32'd0 : w_ld_data;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == c_TIMEOUT) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_RESP: begin
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      wmask_q  <= 4'b0000;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign req_ready_o   = (state_q == S_IDLE);
  assign resp_valid_o  = (state_q == S_RESP);
  assign resp_err_o    = (state_q == S_RESP) && err_q;
  assign resp_rdata_o  = (state_q == S_RESP) ? rdata_q : 32'd0;
  assign mem_wstrobe_o = (state_q == S_ISSUE) && we_q;
  assign mem_rstrobe_o = (state_q == S_ISSUE) && !we_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign mem_wmask_o   = wmask_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_bus_master.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_lsu_bus_master                                            |
// | Description : Self-checking bench for lsu_bus_master. A byte-array         |
// |               reference memory predicts every response; a word-array       |
// |               responder plays the memory side with configurable latency.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_lsu_bus_master;

  localparam int c_TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_wstrobe_o;
  logic        mem_rstrobe_o;
  logic [31:0] mem_rdata_i;
  logic        mem_done_i;

  always #5 clk = ~clk;

  lsu_bus_master #(.TIMEOUT_CYCLES(c_TO)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_wmask_o  (mem_wmask_o),
    .mem_wstrobe_o(mem_wstrobe_o),
    .mem_rstrobe_o(mem_rstrobe_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_done_i   (mem_done_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Memory-side responder: word array, done after rsp_delay WAIT cycles.
  // mem_done_i is left high after an access so the next ISSUE sees it stale.
  // --------------------------------------------------------------------------
  logic [31:0] rsp_mem [16];
  int          rsp_delay;
  bit          rsp_silent;
  int          rsp_cnt;
  bit          rsp_pend;

  always @(negedge clk) begin
    if (rst) begin
      mem_done_i = 1'b0;
      rsp_pend   = 1'b0;
    end else if (mem_wstrobe_o || mem_rstrobe_o) begin
      if (mem_wstrobe_o)
        for (int i = 0; i < 4; i++)
          if (mem_wmask_o[i]) rsp_mem[mem_addr_o[5:2]][8*i +: 8] = mem_wdata_o[8*i +: 8];
      mem_rdata_i = rsp_mem[mem_addr_o[5:2]];
      rsp_cnt     = rsp_delay;
      rsp_pend    = 1'b1;
    end else if (rsp_pend) begin
      if (rsp_silent) begin
        mem_done_i = 1'b0;
      end else if (rsp_cnt == 0) begin
        mem_done_i = 1'b1;
        rsp_pend   = 1'b0;
      end else begin
        mem_done_i = 1'b0;
        rsp_cnt--;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Reference model: byte-addressed memory, RV32I load/store semantics.
  // --------------------------------------------------------------------------
  logic [7:0] ref_b [64];

  task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int d, input bit silent);
    int          n, base, lat, k, strobes;
    bit          bad, seen;
    logic [31:0] exp_rdata, exp_wdata;
    logic [3:0]  exp_wmask;

    n    = 1 << f3[1:0];
    bad  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00)) bad = 1'b1;
`endif
    base      = int'(addr[5:0]) & ~(n - 1);
    exp_rdata = 32'd0;
    exp_wdata = 32'd0;
    exp_wmask = 4'b0000;
    if (!bad) begin
      if (we) begin
        for (int i = 0; i < n; i++) begin
          ref_b[base + i]           = wd[8*i +: 8];
          exp_wmask[(base + i) % 4] = 1'b1;
        end
        for (int j = 0; j < 4; j++) exp_wdata[8*j +: 8] = wd[8*(j % n) +: 8];
      end else if (!silent) begin
        for (int i = 0; i < n; i++) exp_rdata = exp_rdata | (32'(ref_b[base + i]) << (8*i));
        if (!f3[2] && n < 4 && exp_rdata[8*n - 1])
          exp_rdata = exp_rdata | ~((32'd1 << (8*n)) - 32'd1);
      end
    end
    lat = bad ? 1 : (silent ? 3 + c_TO : 3 + d);

    check_eq("ready_before_req", req_ready_o, 1);
    rsp_delay    = d;
    rsp_silent   = silent;
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;

    k       = 1;
    strobes = 0;
    seen    = 1'b0;
    while (!seen && k <= 20) begin
      if (k == 1) check_eq("ready_busy", req_ready_o, 0);
      if (!bad && k < lat) check_eq("mem_addr_hold", mem_addr_o, addr);
      if (mem_wstrobe_o || mem_rstrobe_o) begin
        strobes++;
        check_eq("strobe_cycle", k, 1);
        check_eq("strobe_kind", {30'd0, mem_wstrobe_o, mem_rstrobe_o}, we ? 2 : 1);
        check_eq("wmask", mem_wmask_o, exp_wmask);
        if (we) check_eq("wdata", mem_wdata_o, exp_wdata);
      end
      if (resp_valid_o) begin
        seen = 1'b1;
        check_eq("resp_cycle", k, lat);
        check_eq("resp_err", resp_err_o, bad || silent);
        check_eq("resp_rdata", resp_rdata_o, exp_rdata);
      end
      @(negedge clk);
      k++;
    end
    if (!seen) check_eq("resp_missing", 0, 1);
    check_eq("strobe_count", strobes, bad ? 0 : 1);
    check_eq("resp_one_cycle", resp_valid_o, 0);
  endtask

  // Reset asserted while the unit waits on an unanswered load.
  task automatic reset_mid_txn();
    bit any_resp;
    rsp_silent   = 1'b1;
    rsp_delay    = 0;
    req_valid_i  = 1'b1;
    req_we_i     = 1'b0;
    req_funct3_i = 3'b010;
    req_addr_i   = 32'h20;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    check_eq("rst_test_rstrobe", mem_rstrobe_o, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_mid_ready", req_ready_o, 1);
    check_eq("rst_mid_strobes", {mem_wstrobe_o, mem_rstrobe_o}, 0);
    any_resp = resp_valid_o;
    for (int i = 0; i < c_TO + 4; i++) begin
      @(negedge clk);
      any_resp = any_resp | resp_valid_o;
    end
    check_eq("rst_mid_no_resp", any_resp, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst          = 1'b1;
    req_valid_i  = 1'b0;
    req_we_i     = 1'b0;
    req_funct3_i = 3'd0;
    req_addr_i   = 32'd0;
    req_wdata_i  = 32'd0;
    mem_rdata_i  = 32'd0;
    mem_done_i   = 1'b0;
    rsp_delay    = 0;
    rsp_silent   = 1'b0;
    rsp_cnt      = 0;
    rsp_pend     = 1'b0;
    for (int i = 0; i < 16; i++) rsp_mem[i] = 32'd0;
    for (int i = 0; i < 64; i++) ref_b[i] = 8'd0;

    repeat (3) @(negedge clk);
    check_eq("rst_ready", req_ready_o, 1);
    check_eq("rst_resp_valid", resp_valid_o, 0);
    check_eq("rst_resp_err", resp_err_o, 0);
    check_eq("rst_resp_rdata", resp_rdata_o, 0);
    check_eq("rst_mem_addr", mem_addr_o, 0);
    check_eq("rst_mem_wdata", mem_wdata_o, 0);
    check_eq("rst_mem_wmask", mem_wmask_o, 0);
    check_eq("rst_strobes", {mem_wstrobe_o, mem_rstrobe_o}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed scenarios
    run_txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 1'b0);  // SW
    run_txn(1'b1, 3'b000, 32'h13, 32'h000000A5, 1, 1'b0);  // SB
    run_txn(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0);         // LW  -> A5ADBEEF
    run_txn(1'b0, 3'b000, 32'h13, 32'h0, 2, 1'b0);         // LB  -> FFFFFFA5
    run_txn(1'b0, 3'b100, 32'h13, 32'h0, 0, 1'b0);         // LBU -> 000000A5
    run_txn(1'b0, 3'b001, 32'h12, 32'h0, 3, 1'b0);         // LH  -> FFFFA5AD
    run_txn(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b1);         // no mem_done -> timeout
    run_txn(1'b0, 3'b010, 32'h11, 32'h0, 0, 1'b0);         // misaligned LW
    run_txn(1'b1, 3'b001, 32'h23, 32'h00001234, 0, 1'b0);  // misaligned SH
    run_txn(1'b0, 3'b011, 32'h10, 32'h0, 0, 1'b0);         // illegal funct3
    run_txn(1'b1, 3'b100, 32'h10, 32'h0, 0, 1'b0);         // illegal store width
    reset_mid_txn();

    // Randomized traffic
    for (int t = 0; t < 250; t++) begin
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
              $urandom_range(0, 3), ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
